// File: rtl/mem_arb_pkg.sv
// Shared constants for the SRAM/UART memory arbiter.
// FSM encodings, UART register map, strobe polarity.
package mem_arb_pkg;

  typedef logic [3:0] state_t;

  localparam state_t ST_IDLE      = 4'd0;
  localparam state_t ST_RD        = 4'd1;
  localparam state_t ST_WR_SETUP  = 4'd2;
  localparam state_t ST_WR_PULSE  = 4'd3;
  localparam state_t ST_WR_HOLD   = 4'd4;
  localparam state_t ST_U_RD      = 4'd5;
  localparam state_t ST_U_WR_WAIT = 4'd6;
  localparam state_t ST_U_WR      = 4'd7;
  localparam state_t ST_DONE      = 4'd8;

  localparam int unsigned UART_DATA_DEF = 'hBF00;
  localparam int unsigned UART_STAT_DEF = 'hBF01;

  localparam logic [15:0] INST_ZERO = 16'h0000;

  localparam logic STB_ON  = 1'b0;
  localparam logic STB_OFF = 1'b1;

  function automatic logic stb(input logic act);
    return act ? STB_ON : STB_OFF;
  endfunction

endpackage

// File: rtl/sram_mem_arbiter_if.sv
// Data-port request/ready handshake between pipeline and arbiter.
// Master holds req until the one-cycle ready pulse.
interface sram_mem_arbiter_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 18
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              ready;

  modport master (
    output req, we, addr, wdata,
    input  rdata, ready
  );

  modport slave (
    input  req, we, addr, wdata,
    output rdata, ready
  );
endinterface

// File: rtl/sram_port.sv
// One SRAM chip: registered strobes/address/data, tri-state bus.
// Fetch mode bypasses the address register so pc reaches the chip directly.
module sram_port
  import mem_arb_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 18
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en_d,
  input  logic              oe_d,
  input  logic              we_d,
  input  logic              drive_d,
  input  logic [ADDR_W-1:0] addr_d,
  input  logic [DATA_W-1:0] dout_d,
  input  logic              fetch,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic [DATA_W-1:0] din,
  inout  wire  [DATA_W-1:0] sram_data,
  output logic [ADDR_W-1:0] sram_addr,
  output logic              sram_en,
  output logic              sram_oe,
  output logic              sram_we
);

  logic              drive_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] dout_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sram_en <= STB_OFF;
      sram_oe <= STB_OFF;
      sram_we <= STB_OFF;
      drive_q <= 1'b0;
      addr_q  <= '0;
      dout_q  <= '0;
    end else begin
      sram_en <= en_d;
      sram_oe <= oe_d;
      sram_we <= we_d;
      drive_q <= drive_d;
      addr_q  <= addr_d;
      dout_q  <= dout_d;
    end
  end

  assign sram_data = drive_q ? dout_q : 'z;
  assign din       = sram_data;
  assign sram_addr = fetch ? fetch_addr : addr_q;

endmodule

// File: rtl/sram_mem_arbiter.sv
// Data-port FSM arbitrating SRAM1, SRAM2 and the serial port.
// SRAM2 serves instruction fetch whenever the data port is elsewhere.
module sram_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 18,
  parameter int PC_W   = 16,
  parameter logic [ADDR_W-1:0] BANK_SPLIT =
    ADDR_W'('h8000),
  parameter logic [ADDR_W-1:0] UART_DATA_ADDR =
    ADDR_W'(UART_DATA_DEF),
  parameter logic [ADDR_W-1:0] UART_STAT_ADDR =
    ADDR_W'(UART_STAT_DEF),
  parameter int RD_WAIT  = 0,
  parameter int WR_PULSE = 1
) (
  input  logic              clk_50MHz,
  input  logic              rst,
  sram_mem_arbiter_if.slave bus,
  output logic              ram_pause,
  input  logic [PC_W-1:0]   pc,
  output logic [DATA_W-1:0] inst,
  output logic              inst_valid,
  inout  wire  [DATA_W-1:0] sram1_data,
  inout  wire  [DATA_W-1:0] sram2_data,
  output logic [ADDR_W-1:0] sram1_addr,
  output logic [ADDR_W-1:0] sram2_addr,
  output logic              sram1_en,
  output logic              sram1_oe,
  output logic              sram1_we,
  output logic              sram2_en,
  output logic              sram2_oe,
  output logic              sram2_we,
  input  logic              tsre,
  input  logic              tbre,
  input  logic              data_ready,
  output logic              rdn,
  output logic              wrn
);

  state_t            state, nxt;
  logic [2:0]        cnt, cnt_n;
  logic [ADDR_W-1:0] l_addr, la_n;
  logic [DATA_W-1:0] l_wdata, lwd_n;
  logic              l_s2, ls2_n;
  logic              l_uw, luw_n;
  logic [DATA_W-1:0] rdata_q, rd_n;
  logic              fetch_q;
  logic [DATA_W-1:0] s1_din, s2_din;

  always_comb begin
    nxt   = state;
    cnt_n = cnt;
    la_n  = l_addr;
    lwd_n = l_wdata;
    ls2_n = l_s2;
    luw_n = l_uw;
    rd_n  = rdata_q;
    unique case (state)
      ST_IDLE: if (bus.req) begin
        la_n  = bus.addr;
        lwd_n = bus.wdata;
        ls2_n = bus.addr < BANK_SPLIT;
        luw_n = 1'b0;
        if (bus.addr == UART_STAT_ADDR) begin
          ls2_n = 1'b0;
          nxt   = ST_DONE;
          rd_n  = {{(DATA_W-2){1'b0}},
                   data_ready, tsre & tbre};
        end else if (bus.addr == UART_DATA_ADDR) begin
          ls2_n = 1'b0;
          if (bus.we) begin
            luw_n = 1'b1;
            nxt   = ST_U_WR_WAIT;
          end else if (data_ready) begin
            nxt   = ST_U_RD;
            cnt_n = 3'd1;
          end else begin
            nxt   = ST_DONE;
            rd_n  = '0;
          end
        end else if (bus.we) begin
          nxt = ST_WR_SETUP;
        end else begin
          nxt   = ST_RD;
          cnt_n = 3'(RD_WAIT);
        end
      end
      ST_RD: if (cnt == 3'd0) begin
        nxt  = ST_DONE;
        rd_n = l_s2 ? s2_din : s1_din;
      end else begin
        cnt_n = cnt - 3'd1;
      end
      ST_WR_SETUP: begin
        nxt   = ST_WR_PULSE;
        cnt_n = 3'(WR_PULSE - 1);
      end
      ST_WR_PULSE: if (cnt == 3'd0) nxt = ST_WR_HOLD;
                   else cnt_n = cnt - 3'd1;
      ST_WR_HOLD: nxt = ST_DONE;
      ST_U_RD: if (cnt == 3'd0) begin
        nxt  = ST_DONE;
        rd_n = s1_din;
      end else begin
        cnt_n = cnt - 3'd1;
      end
      ST_U_WR_WAIT: if (tsre & tbre) begin
        nxt   = ST_U_WR;
        cnt_n = 3'(WR_PULSE - 1);
      end
      ST_U_WR: if (cnt == 3'd0) nxt = ST_DONE;
               else cnt_n = cnt - 3'd1;
      ST_DONE: nxt = ST_IDLE;
      default: nxt = ST_IDLE;
    endcase
  end

  // Strobes are decoded from the next state and registered in the ports.
  logic rd_st, wr_st, pl_st, uw_st, s1_sel, s2_sel;
  assign rd_st  = nxt == ST_RD;
  assign wr_st  = nxt inside {ST_WR_SETUP,
                              ST_WR_PULSE, ST_WR_HOLD};
  assign pl_st  = nxt == ST_WR_PULSE;
  assign uw_st  = nxt inside {ST_U_WR_WAIT, ST_U_WR}
                  || (nxt == ST_DONE && luw_n);
  assign s2_sel = (rd_st | wr_st) & ls2_n;
  assign s1_sel = (rd_st | wr_st) & ~ls2_n;

  always_ff @(posedge clk_50MHz or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      l_addr  <= '0;
      l_wdata <= '0;
      l_s2    <= 1'b0;
      l_uw    <= 1'b0;
      rdata_q <= '0;
      fetch_q <= 1'b0;
      rdn     <= STB_OFF;
      wrn     <= STB_OFF;
    end else begin
      state   <= nxt;
      cnt     <= cnt_n;
      l_addr  <= la_n;
      l_wdata <= lwd_n;
      l_s2    <= ls2_n;
      l_uw    <= luw_n;
      rdata_q <= rd_n;
      fetch_q <= ~s2_sel;
      rdn     <= stb(nxt == ST_U_RD);
      wrn     <= stb(nxt == ST_U_WR);
    end
  end

  sram_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_sram1 (
    .clk        (clk_50MHz),
    .rst_n      (rst),
    .en_d       (stb(s1_sel)),
    .oe_d       (stb(s1_sel & rd_st)),
    .we_d       (stb(s1_sel & pl_st)),
    .drive_d    ((s1_sel & wr_st) | uw_st),
    .addr_d     (la_n),
    .dout_d     (lwd_n),
    .fetch      (1'b0),
    .fetch_addr ('0),
    .din        (s1_din),
    .sram_data  (sram1_data),
    .sram_addr  (sram1_addr),
    .sram_en    (sram1_en),
    .sram_oe    (sram1_oe),
    .sram_we    (sram1_we)
  );

  sram_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_sram2 (
    .clk        (clk_50MHz),
    .rst_n      (rst),
    .en_d       (STB_ON),
    .oe_d       (stb(~(s2_sel & wr_st))),
    .we_d       (stb(s2_sel & pl_st)),
    .drive_d    (s2_sel & wr_st),
    .addr_d     (la_n),
    .dout_d     (lwd_n),
    .fetch      (fetch_q),
    .fetch_addr (ADDR_W'(pc)),
    .din        (s2_din),
    .sram_data  (sram2_data),
    .sram_addr  (sram2_addr),
    .sram_en    (sram2_en),
    .sram_oe    (sram2_oe),
    .sram_we    (sram2_we)
  );

  assign bus.ready  = state == ST_DONE;
  assign bus.rdata  = rdata_q;
  assign ram_pause  = bus.req & ~bus.ready;
  assign inst_valid = fetch_q;
  assign inst = fetch_q ? s2_din : DATA_W'(INST_ZERO);

endmodule

// File: tb/tb_sram_mem_arbiter.sv
// Directed bench for sram_mem_arbiter with SRAM and UART models.
// Built with RD_WAIT=1, WR_PULSE=2.
module tb_sram_mem_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sram_mem_arbiter_if #(.DATA_W(16), .ADDR_W(18)) bus ();

  logic        ram_pause;
  logic [15:0] pc;
  logic [15:0] inst;
  logic        inst_valid;
  wire  [15:0] sram1_data;
  wire  [15:0] sram2_data;
  logic [17:0] sram1_addr, sram2_addr;
  logic        sram1_en, sram1_oe, sram1_we;
  logic        sram2_en, sram2_oe, sram2_we;
  logic        tsre, tbre, data_ready;
  logic        rdn, wrn;
  logic [15:0] uart_rx;

  int n_chk  = 0;
  int n_pass = 0;

  sram_mem_arbiter #(.RD_WAIT(1), .WR_PULSE(2)) dut (
    .clk_50MHz  (clk),
    .rst        (rst),
    .bus        (bus),
    .ram_pause  (ram_pause),
    .pc         (pc),
    .inst       (inst),
    .inst_valid (inst_valid),
    .sram1_data (sram1_data),
    .sram2_data (sram2_data),
    .sram1_addr (sram1_addr),
    .sram2_addr (sram2_addr),
    .sram1_en   (sram1_en),
    .sram1_oe   (sram1_oe),
    .sram1_we   (sram1_we),
    .sram2_en   (sram2_en),
    .sram2_oe   (sram2_oe),
    .sram2_we   (sram2_we),
    .tsre       (tsre),
    .tbre       (tbre),
    .data_ready (data_ready),
    .rdn        (rdn),
    .wrn        (wrn)
  );

  // SRAM2 holds {C0,idx} except for the last written word.
  logic        w2_v = 1'b0;
  logic [7:0]  w2_a;
  logic [15:0] w2_d;
  always @(posedge sram2_we)
    if (!sram2_en) begin
      w2_v <= 1'b1;
      w2_a <= sram2_addr[7:0];
      w2_d <= sram2_data;
    end

  function automatic logic [15:0] m2(input logic [7:0] i);
    return (w2_v && w2_a == i) ? w2_d : {8'hC0, i};
  endfunction

  logic [15:0] m1;
  assign m1 = (sram1_addr == 18'h09000) ? 16'h1234 : 16'hDEAD;

  assign sram1_data = (!sram1_en && !sram1_oe && sram1_we) ? m1 :
                      (!rdn ? uart_rx : 16'hzzzz);
  assign sram2_data = (!sram2_en && !sram2_oe && sram2_we) ?
                      m2(sram2_addr[7:0]) : 16'hzzzz;

  task automatic issue(input logic w, input logic [17:0] a,
                       input logic [15:0] d);
    @(negedge clk);
    bus.we    = w;
    bus.addr  = a;
    bus.wdata = d;
    bus.req   = 1'b1;
  endtask

  task automatic test_reset;
    @(negedge clk);
    n_chk++;
    if ({sram1_en, sram1_oe, sram1_we} !== 3'b111)
      $display("FAIL rst_s1_strobes: got %b want 111",
               {sram1_en, sram1_oe, sram1_we});
    else n_pass++;
    n_chk++;
    if ({sram2_en, sram2_oe, sram2_we} !== 3'b111)
      $display("FAIL rst_s2_strobes: got %b want 111",
               {sram2_en, sram2_oe, sram2_we});
    else n_pass++;
    n_chk++;
    if ({rdn, wrn} !== 2'b11)
      $display("FAIL rst_uart: got %b want 11", {rdn, wrn});
    else n_pass++;
    n_chk++;
    if (bus.ready !== 1'b0 || bus.rdata !== 16'h0)
      $display("FAIL rst_port: got ready=%b rdata=%h want 0/0000",
               bus.ready, bus.rdata);
    else n_pass++;
    n_chk++;
    if (sram1_addr !== 18'h0 || sram2_addr !== 18'h0)
      $display("FAIL rst_addr: got %h/%h want 0/0",
               sram1_addr, sram2_addr);
    else n_pass++;
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    n_chk++;
    if (inst_valid !== 1'b1 || inst !== 16'hC010)
      $display("FAIL fetch_after_rst: got %b/%h want 1/c010",
               inst_valid, inst);
    else n_pass++;
  endtask

  task automatic test_wr_reset;
    bit found = 0;
    int bad = 0;
    issue(1'b1, 18'h00100, 16'h5A5A);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (!sram2_we) begin found = 1; break; end
    end
    n_chk++;
    if (!found)
      $display("FAIL mid_wr_pulse: got no we pulse want pulse");
    else n_pass++;
    #2 rst = 1'b0;
    #1;
    n_chk++;
    if (sram2_we !== 1'b1 || sram2_en !== 1'b1)
      $display("FAIL mid_wr_rst_we: got we=%b en=%b want 1/1",
               sram2_we, sram2_en);
    else n_pass++;
    n_chk++;
    if (sram2_data === 16'h5A5A)
      $display("FAIL mid_wr_rst_bus: got %h want released",
               sram2_data);
    else n_pass++;
    bus.req = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (bus.ready !== 1'b0 || ram_pause !== 1'b0) bad++;
    end
    n_chk++;
    if (bad != 0)
      $display("FAIL mid_wr_idle: got %0d busy cycles want 0", bad);
    else n_pass++;
  endtask

  task automatic test_sram_write;
    int rc = 0, wl = 0, bad = 0, iv = 0, pb = 0;
    logic rp = 1'b1;
    issue(1'b1, 18'h00100, 16'hA5A5);
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (bus.ready) begin rc = c; rp = ram_pause; break; end
      if (!sram2_we) begin
        wl++;
        if (sram2_data !== 16'hA5A5 ||
            sram2_addr !== 18'h00100) bad++;
      end
      if (inst_valid) iv++;
      if (!ram_pause) pb++;
    end
    bus.req = 1'b0;
    n_chk++;
    if (rc != 5) $display("FAIL wr_latency: got %0d want 5", rc);
    else n_pass++;
    n_chk++;
    if (wl != 2) $display("FAIL wr_pulse: got %0d want 2", wl);
    else n_pass++;
    n_chk++;
    if (bad != 0) $display("FAIL wr_bus: got %0d bad want 0", bad);
    else n_pass++;
    n_chk++;
    if (iv != 0) $display("FAIL wr_fetch_block: got %0d want 0", iv);
    else n_pass++;
    n_chk++;
    if (pb != 0 || rp !== 1'b0)
      $display("FAIL wr_pause: got %0d/%b want 0/0", pb, rp);
    else n_pass++;
    @(negedge clk);
    pc = 16'h0100;
    #1;
    n_chk++;
    if (inst !== 16'hA5A5 || inst_valid !== 1'b1)
      $display("FAIL wr_readback: got %h want a5a5", inst);
    else n_pass++;
  endtask

  task automatic test_sram_read;
    int rc = 0, ol = 0, ivl = 0;
    issue(1'b0, 18'h09000, 16'h0);
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (!inst_valid) ivl++;
      if (bus.ready) begin rc = c; break; end
      if (!sram1_oe) ol++;
    end
    n_chk++;
    if (rc != 3) $display("FAIL rd_latency: got %0d want 3", rc);
    else n_pass++;
    n_chk++;
    if (bus.rdata !== 16'h1234)
      $display("FAIL rd_data: got %h want 1234", bus.rdata);
    else n_pass++;
    bus.req = 1'b0;
    n_chk++;
    if (ol != 2) $display("FAIL rd_oe: got %0d want 2", ol);
    else n_pass++;
    n_chk++;
    if (ivl != 0) $display("FAIL rd_fetch: got %0d want 0", ivl);
    else n_pass++;
  endtask

  task automatic test_status;
    int rc = 0, sa = 0;
    data_ready = 1'b1; tsre = 1'b1; tbre = 1'b0;
    issue(1'b0, 18'h0BF01, 16'h0);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (!sram1_en || !sram2_we || !rdn || !wrn) sa++;
      if (bus.ready) begin rc = c; break; end
    end
    n_chk++;
    if (rc != 1) $display("FAIL stat_latency: got %0d want 1", rc);
    else n_pass++;
    n_chk++;
    if (bus.rdata !== 16'h0002)
      $display("FAIL stat_data: got %h want 0002", bus.rdata);
    else n_pass++;
    bus.req = 1'b0;
    n_chk++;
    if (sa != 0) $display("FAIL stat_strobes: got %0d want 0", sa);
    else n_pass++;
  endtask

  task automatic test_uart_write;
    int rc = 0, wl = 0, first = 0, bad = 0, e1 = 0;
    data_ready = 1'b0; tsre = 1'b0; tbre = 1'b0;
    issue(1'b1, 18'h0BF00, 16'h0041);
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (!sram1_en) e1++;
      if (bus.ready) begin rc = c; break; end
      if (!wrn) begin
        wl++;
        if (first == 0) first = c;
        if (sram1_data !== 16'h0041) bad++;
      end
      if (c == 4) begin tsre = 1'b1; tbre = 1'b1; end
    end
    bus.req = 1'b0;
    n_chk++;
    if (first != 5)
      $display("FAIL uw_wait: got wrn low at %0d want 5", first);
    else n_pass++;
    n_chk++;
    if (wl != 2) $display("FAIL uw_pulse: got %0d want 2", wl);
    else n_pass++;
    n_chk++;
    if (bad != 0) $display("FAIL uw_data: got %0d bad want 0", bad);
    else n_pass++;
    n_chk++;
    if (rc != 7) $display("FAIL uw_latency: got %0d want 7", rc);
    else n_pass++;
    n_chk++;
    if (e1 != 0) $display("FAIL uw_sram1_en: got %0d want 0", e1);
    else n_pass++;
  endtask

  task automatic test_uart_read(input logic dr,
                                input int exp_rc,
                                input int exp_rl,
                                input logic [15:0] exp_d);
    int rc = 0, rl = 0;
    data_ready = dr;
    issue(1'b0, 18'h0BF00, 16'h0);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (bus.ready) begin rc = c; break; end
      if (!rdn) rl++;
    end
    bus.req = 1'b0;
    n_chk++;
    if (rc != exp_rc)
      $display("FAIL ur_latency: got %0d want %0d", rc, exp_rc);
    else n_pass++;
    n_chk++;
    if (bus.rdata !== exp_d)
      $display("FAIL ur_data: got %h want %h", bus.rdata, exp_d);
    else n_pass++;
    n_chk++;
    if (rl != exp_rl)
      $display("FAIL ur_rdn: got %0d want %0d", rl, exp_rl);
    else n_pass++;
  endtask

  task automatic test_fetch;
    @(negedge clk);
    pc = 16'h0033;
    #1;
    n_chk++;
    if (inst !== 16'hC033 || inst_valid !== 1'b1)
      $display("FAIL fetch_comb: got %b/%h want 1/c033",
               inst_valid, inst);
    else n_pass++;
  endtask

  initial begin
    rst        = 1'b0;
    bus.req    = 1'b0;
    bus.we     = 1'b0;
    bus.addr   = '0;
    bus.wdata  = '0;
    pc         = 16'h0010;
    tsre       = 1'b1;
    tbre       = 1'b1;
    data_ready = 1'b0;
    uart_rx    = 16'h0055;
    test_reset();
    test_wr_reset();
    test_sram_write();
    test_sram_read();
    test_status();
    test_uart_write();
    test_uart_read(1'b0, 1, 0, 16'h0000);
    test_uart_read(1'b1, 3, 2, 16'h0055);
    test_fetch();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/sram_mem_arbiter.md
# sram_mem_arbiter

Registered, parametrised memory controller between the CPU pipeline and the two on-board SRAM chips plus the memory-mapped serial port. It replaces clock-level gating of write strobes with a cycle-accurate strobe sequencer. It adds configurable bank split, read wait states and write-pulse width, and gives the data port a request/ready handshake. Instruction fetch uses SRAM2 whenever the data port does not own it.

## Interface
- DATA_W, 16, data/instruction word width
- ADDR_W, 18, SRAM address width
- PC_W, 16, fetch address width (zero-extended to ADDR_W)
- BANK_SPLIT, 18'h8000, addresses below go to SRAM2, at/above go to SRAM1
- UART_DATA_ADDR, 18'hBF00, serial data register
- UART_STAT_ADDR, 18'hBF01, serial status register
- RD_WAIT, 0, extra read wait cycles (0..7)
- WR_PULSE, 1, write-strobe low cycles (1..7)

Ports:
- clk_50MHz  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- req  in  1  data request; held high until ready
- we  in  1  1 = write, 0 = read
- addr  in  ADDR_W  data address
- wdata  in  DATA_W  write data
- rdata  out  DATA_W  read data, valid with ready
- ready  out  1  one-cycle completion pulse
- ram_pause  out  1  pipeline stall
- pc  in  PC_W  fetch address
- inst  out  DATA_W  fetched instruction; INST_ZERO when fetch is blocked
- inst_valid  out  1  inst is from SRAM2 this cycle
- sram1_data, sram2_data  inout  DATA_W  SRAM buses
- sram1_addr, sram2_addr  out  ADDR_W
- sram1_en/oe/we, sram2_en/oe/we  out  1  active-low strobes
- tsre, tbre, data_ready  in  1  UART status
- rdn, wrn  out  1  UART strobes, active-low

## Operation
- Data-port FSM states:
  - IDLE
  - RD (1+RD_WAIT cycles)
  - WR_SETUP
  - WR_PULSE (WR_PULSE cycles)
  - WR_HOLD
  - U_RD
  - U_WR_WAIT
  - U_WR
  - DONE
- IDLE accepts req on a rising edge and decodes the target:
  - addr==UART_STAT_ADDR: go to DONE with rdata={0,data_ready,tsre&tbre}; a write here is ignored.
  - addr==UART_DATA_ADDR, read: go to U_RD if data_ready=1; otherwise go to DONE with rdata=0.
  - addr==UART_DATA_ADDR, write: go to U_WR_WAIT.
  - addr<BANK_SPLIT: target SRAM2. Otherwise: target SRAM1.
- RD: en=0, oe=0, we=1; rdata is captured on the last RD cycle.
- Writes: addr and wdata are driven from WR_SETUP through WR_HOLD. we=0 only in WR_PULSE. oe=1 throughout.
- U_RD: SRAM1 disabled, rdn=0 for 2 cycles, sram1_data captured on the second.
- U_WR_WAIT: holds until tsre&tbre=1.
- U_WR: wdata driven on sram1_data, wrn=0 for WR_PULSE cycles.
- DONE: ready=1 for one cycle, then IDLE. req is not sampled in DONE.
- Fetch:
  - When the FSM is not on an SRAM2 access, SRAM2 has en=0, oe=0, we=1 and address {0,pc}; inst=sram2_data and inst_valid=1.
  - While the FSM is on an SRAM2 access, inst=INST_ZERO and inst_valid=0.
- ram_pause = req & ~ready (combinational).
- Unselected chip: en=oe=we=1, bus high-Z. The controller drives a bus only in write or UART-write states.

## Timing
- Reset (async, rst=0):
  - state IDLE
  - all SRAM strobes 1, rdn=wrn=1
  - buses high-Z
  - rdata=0, ready=0
  - sram addresses 0
- Reset mid-write releases we and the bus immediately.
- Strobes are registered outputs; they are glitch-free with no clock gating.
- Latency from the accepting edge to the ready pulse:
  - SRAM read: 2+RD_WAIT cycles.
  - SRAM write: 3+WR_PULSE cycles.
  - Status read: 1 cycle.
  - UART read: 3 cycles.
  - UART write: 2+WR_PULSE cycles plus wait time.
- Address and data stay stable ≥1 cycle before and after we/wrn low.
- inst has zero-cycle (combinational) latency from pc while inst_valid=1.
- A request change while busy is ignored; the latched addr/we/wdata are used.

## Structure
- Package mem_arb_pkg:
  - FSM state enum
  - default UART addresses
  - INST_ZERO
  - strobe active/inactive constants
- Sub-module sram_port: registered strobes, address register, tri-state driver. Instantiated twice, once per chip.
- Wait counter: 3 bits, shared by RD, WR_PULSE and U_WR.

## Test plan
- Reset mid-WR_PULSE to addr 18'h0100 -> sram2_we=1 and bus Z same cycle; after release, IDLE with ready=0.
- Write 16'hA5A5 to 18'h0100, WR_PULSE=2 -> sram2_we low exactly 2 cycles; ready at cycle 5; inst_valid=0 for those cycles; ram_pause high until ready.
- Read 18'h9000, RD_WAIT=1, model returns 16'h1234 -> rdata=16'h1234, ready at cycle 3; fetch unaffected (inst_valid=1).
- Status read 18'hBF01 with data_ready=1, tsre=1, tbre=0 -> rdata=16'h0002 after 1 cycle; no SRAM strobe asserted.
- UART write 16'h0041 with tsre&tbre low for 4 cycles -> wrn stays 1 for those cycles, then low WR_PULSE cycles with data on sram1_data; ready follows.
- UART read with data_ready=0 -> rdata=0, rdn never low, ready after 1 cycle.
